if_id_pipe_reg: RTL and testbench

//  Parametrised IF/ID pipeline register with valid/ready handshake, 2-entry skid buffer,

---
 rtl/if_id_pipe_reg.sv | 139 +++++++++++++
 tb/tb_if_id_pipe_reg.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register: valid/ready handshake with a two-entry skid buffer,
// synchronous flush to a bubble, and a saturating decode-stall counter.
module if_id_pipe_reg #(
    parameter int                INST_W      = 32,
    parameter int                PC_W        = 32,
    parameter logic [INST_W-1:0] NOP_INST    = 32'h0000_0013,
    parameter int                STALL_CNT_W = 16
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INST_W-1:0]      in_inst,
    input  logic [PC_W-1:0]        in_pc,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INST_W-1:0]      out_inst,
    output logic [PC_W-1:0]        out_pc,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;
    localparam logic [STALL_CNT_W-1:0] STALL_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [PC_W-1:0]        PC_ZERO   = '0;

    logic                   r_main_vld, r_skid_vld, r_in_ready;
    logic [INST_W-1:0]      r_main_inst, r_skid_inst;
    logic [PC_W-1:0]        r_main_pc, r_skid_pc;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    logic                   w_accept, w_consume;
    logic                   w_main_vld_nxt, w_skid_vld_nxt, w_in_ready_nxt;
    logic [INST_W-1:0]      w_main_inst_nxt, w_skid_inst_nxt;
    logic [PC_W-1:0]        w_main_pc_nxt, w_skid_pc_nxt;
    logic [STALL_CNT_W-1:0] w_stall_cnt_nxt;

    // Next-state for the main/skid storage; main data is forced to a bubble whenever it empties.
    always_comb begin
        w_accept        = in_valid & r_in_ready;
        w_consume       = r_main_vld & out_ready;
        w_main_vld_nxt  = r_main_vld;
        w_skid_vld_nxt  = r_skid_vld;
        w_main_inst_nxt = r_main_inst;
        w_main_pc_nxt   = r_main_pc;
        w_skid_inst_nxt = r_skid_inst;
        w_skid_pc_nxt   = r_skid_pc;
        if (flush) begin
            w_main_vld_nxt  = 1'b0;
            w_skid_vld_nxt  = 1'b0;
            w_main_inst_nxt = NOP_INST;
            w_main_pc_nxt   = PC_ZERO;
        end else begin
            case ({r_main_vld, r_skid_vld})
                2'b00: begin
                    if (w_accept) begin
                        w_main_vld_nxt  = 1'b1;
                        w_main_inst_nxt = in_inst;
                        w_main_pc_nxt   = in_pc;
                    end else begin
                        w_main_vld_nxt  = 1'b0;
                    end
                end
                2'b10: begin
                    if (w_accept && w_consume) begin
                        w_main_inst_nxt = in_inst;
                        w_main_pc_nxt   = in_pc;
                    end else if (w_accept) begin
                        w_skid_vld_nxt  = 1'b1;
                        w_skid_inst_nxt = in_inst;
                        w_skid_pc_nxt   = in_pc;
                    end else if (w_consume) begin
                        w_main_vld_nxt  = 1'b0;
                        w_main_inst_nxt = NOP_INST;
                        w_main_pc_nxt   = PC_ZERO;
                    end else begin
                        w_main_vld_nxt  = 1'b1;
                    end
                end
                2'b11: begin
                    if (w_consume) begin
                        w_skid_vld_nxt  = 1'b0;
                        w_main_inst_nxt = r_skid_inst;
                        w_main_pc_nxt   = r_skid_pc;
                    end else begin
                        w_skid_vld_nxt  = 1'b1;
                    end
                end
                default: begin
                    // Skid-only is unreachable; recover to a clean bubble.
                    w_main_vld_nxt  = 1'b0;
                    w_skid_vld_nxt  = 1'b0;
                    w_main_inst_nxt = NOP_INST;
                    w_main_pc_nxt   = PC_ZERO;
                end
            endcase
        end
        w_in_ready_nxt = ~(w_main_vld_nxt & w_skid_vld_nxt);
    end

    // Saturating count of edges where decode holds off a valid word.
    always_comb begin
        if (r_main_vld && !out_ready && !flush && (r_stall_cnt != STALL_MAX)) begin
            w_stall_cnt_nxt = r_stall_cnt + STALL_ONE;
        end else begin
            w_stall_cnt_nxt = r_stall_cnt;
        end
    end

    // State and data registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_main_vld  <= 1'b0;
            r_skid_vld  <= 1'b0;
            r_in_ready  <= 1'b1;
            r_main_inst <= NOP_INST;
            r_main_pc   <= PC_ZERO;
            r_skid_inst <= NOP_INST;
            r_skid_pc   <= PC_ZERO;
            r_stall_cnt <= '0;
        end else begin
            r_main_vld  <= w_main_vld_nxt;
            r_skid_vld  <= w_skid_vld_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_main_inst <= w_main_inst_nxt;
            r_main_pc   <= w_main_pc_nxt;
            r_skid_inst <= w_skid_inst_nxt;
            r_skid_pc   <= w_skid_pc_nxt;
            r_stall_cnt <= w_stall_cnt_nxt;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_main_vld;
    assign out_inst  = r_main_inst;
    assign out_pc    = r_main_pc;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Bench for if_id_pipe_reg: directed vector table, reset/saturation sequences,
// and a random run against a FIFO scoreboard.
module tb_if_id_pipe_reg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clock, resetn;
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] in_inst, in_pc, out_inst, out_pc;
    logic [15:0] stall_cnt;

    logic        s_in_valid, s_in_ready, s_flush, s_out_valid, s_out_ready;
    logic [31:0] s_in_inst, s_in_pc, s_out_inst, s_out_pc;
    logic [3:0]  s_stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    if_id_pipe_reg dut (
        .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc), .stall_cnt(stall_cnt)
    );

    if_id_pipe_reg #(.STALL_CNT_W(4)) dut_sat (
        .clock(clock), .resetn(resetn), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_inst(s_in_inst), .in_pc(s_in_pc), .flush(s_flush), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .out_inst(s_out_inst), .out_pc(s_out_pc), .stall_cnt(s_stall_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        iv;
        logic [31:0] pc;
        logic        fl;
        logic        ordy;
        logic        e_ov;
        logic [31:0] e_pc;
        logic        e_ir;
        logic [15:0] e_st;
    } vec_t;

    vec_t        tbl [17];
    logic [31:0] sb_q [$];
    logic [15:0] sb_stall;
    logic [31:0] nxt_pc;
    logic [31:0] e_pc_v;
    logic        acc, ov_m;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return {pc[15:0], 16'hC0DE};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [31:0] pc, input logic fl, input logic ordy);
        in_valid  = iv;
        in_pc     = pc;
        in_inst   = inst_of(pc);
        flush     = fl;
        out_ready = ordy;
    endtask

    task automatic chk_all(input string nm, input logic ov, input logic [31:0] pc,
                           input logic ir, input logic [15:0] st);
        chk({nm, " out_valid"}, 128'(out_valid), 128'(ov));
        chk({nm, " out_pc"},    128'(out_pc),    128'(ov ? pc : 32'h0));
        chk({nm, " out_inst"},  128'(out_inst),  128'(ov ? inst_of(pc) : NOP));
        chk({nm, " in_ready"},  128'(in_ready),  128'(ir));
        chk({nm, " stall_cnt"}, 128'(stall_cnt), 128'(st));
    endtask

    initial begin
        // iv  pc      fl    ordy  | e_ov  e_pc    e_ir  e_st
        tbl[0]  = '{1'b1, 32'h00, 1'b0, 1'b1, 1'b1, 32'h00, 1'b1, 16'd0};
        tbl[1]  = '{1'b1, 32'h04, 1'b0, 1'b1, 1'b1, 32'h04, 1'b1, 16'd0};
        tbl[2]  = '{1'b1, 32'h08, 1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 16'd0};
        tbl[3]  = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 16'd0};
        tbl[4]  = '{1'b1, 32'h10, 1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 16'd0};
        tbl[5]  = '{1'b1, 32'h14, 1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 16'd1};
        tbl[6]  = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 16'd2};
        tbl[7]  = '{1'b1, 32'h18, 1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 16'd3};
        tbl[8]  = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b1, 32'h14, 1'b1, 16'd3};
        tbl[9]  = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 16'd3};
        tbl[10] = '{1'b1, 32'h20, 1'b0, 1'b0, 1'b1, 32'h20, 1'b1, 16'd3};
        tbl[11] = '{1'b1, 32'h24, 1'b0, 1'b0, 1'b1, 32'h20, 1'b0, 16'd4};
        tbl[12] = '{1'b1, 32'h18, 1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 16'd4};
        tbl[13] = '{1'b1, 32'h28, 1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 16'd4};
        tbl[14] = '{1'b1, 32'h2C, 1'b0, 1'b1, 1'b1, 32'h2C, 1'b1, 16'd4};
        tbl[15] = '{1'b1, 32'h30, 1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 16'd4};
        tbl[16] = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 16'd4};

        resetn = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        s_in_valid = 1'b0; s_in_pc = 32'h0; s_in_inst = 32'h0; s_flush = 1'b0; s_out_ready = 1'b1;
        tick();
        tick();
        chk_all("reset", 1'b0, 32'h0, 1'b1, 16'd0);
        resetn = 1'b1;
        tick();
        chk_all("idle", 1'b0, 32'h0, 1'b1, 16'd0);

        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].iv, tbl[i].pc, tbl[i].fl, tbl[i].ordy);
            tick();
            chk_all($sformatf("vec%0d", i), tbl[i].e_ov, tbl[i].e_pc, tbl[i].e_ir, tbl[i].e_st);
        end

        // Fill to FULL, then assert reset between edges.
        drive(1'b1, 32'h40, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h44, 1'b0, 1'b0);
        tick();
        chk_all("pre_reset_full", 1'b1, 32'h40, 1'b0, 16'd5);
        #3;
        resetn = 1'b0;
        #1;
        chk_all("async_reset", 1'b0, 32'h0, 1'b1, 16'd0);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        resetn = 1'b1;
        chk_all("reset_released", 1'b0, 32'h0, 1'b1, 16'd0);
        drive(1'b1, 32'h50, 1'b0, 1'b1);
        tick();
        chk_all("first_after_reset", 1'b1, 32'h50, 1'b1, 16'd0);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        chk_all("drain_after_reset", 1'b0, 32'h0, 1'b1, 16'd0);

        // Saturation on the 4-bit counter instance.
        s_in_valid = 1'b1; s_in_pc = 32'h60; s_in_inst = inst_of(32'h60); s_out_ready = 1'b0;
        tick();
        s_in_valid = 1'b0;
        chk("sat_start", 128'(s_stall_cnt), 128'(4'd0));
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk($sformatf("sat_cycle%0d", k), 128'(s_stall_cnt), 128'((k > 15) ? 15 : k));
        end
        chk("sat_out_hold", 128'({s_out_valid, s_out_pc}), 128'({1'b1, 32'h60}));

        // Random traffic against a FIFO scoreboard.
        sb_stall = 16'd0;
        nxt_pc   = 32'h1000;
        for (int c = 0; c < 10000; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 19) == 0);
            in_pc     = in_valid ? nxt_pc : $urandom;
            in_inst   = in_valid ? inst_of(nxt_pc) : $urandom;
            acc  = in_valid && (sb_q.size() < 2);
            ov_m = (sb_q.size() > 0);
            if (ov_m && !out_ready && !flush && sb_stall != 16'hFFFF) sb_stall = sb_stall + 16'd1;
            if (flush) begin
                sb_q.delete();
            end else begin
                if (ov_m && out_ready) void'(sb_q.pop_front());
                if (acc) sb_q.push_back(nxt_pc);
            end
            if (acc) nxt_pc = nxt_pc + 32'd4;
            tick();
            e_pc_v = (sb_q.size() > 0) ? sb_q[0] : 32'h0;
            chk($sformatf("rand%0d {ov,ir,pc,inst,st}", c),
                128'({out_valid, in_ready, out_pc, out_inst, stall_cnt}),
                128'({(sb_q.size() > 0), (sb_q.size() < 2), e_pc_v,
                      (sb_q.size() > 0) ? inst_of(e_pc_v) : NOP, sb_stall}));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
